nibble_packer: RTL and testbench

//  Inverse of the 16->4 nibble select mux: gathers a stream of 4-bit nibbles into 16-bit words.

---
 rtl/nibble_packer_pkg.sv | 8 +
 rtl/nibble_packer_word_hold_reg.sv | 24 ++
 rtl/nibble_packer.sv | 57 +++++
 tb/tb_nibble_packer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_pkg.sv
// nibble_packer_pkg: default geometry shared by the nibble packer and its consumers
package nibble_packer_pkg;
  localparam int NIB_W_DEF = 4;
  localparam int NIBS_DEF = 4;
  localparam int WORD_W_DEF = NIB_W_DEF * NIBS_DEF;
  localparam int PTR_W_DEF = $clog2(NIBS_DEF);
  localparam int CNT_W_DEF = PTR_W_DEF + 1;
endpackage

// File: rtl/nibble_packer_word_hold_reg.sv
// word_hold_reg: single-entry valid/ready holding register; load only when out_free, d/q carry {count, word}
module word_hold_reg #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] q,
  output logic         out_free
);
  assign out_free = !out_valid | out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q <= '0;
    end else begin
      out_valid <= load | (out_valid & !out_ready);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: packs a valid/ready nibble stream into words (nibble k -> bits [4k+3:4k]), flush emits a partial word with its count
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEF,
  parameter int NIBS = NIBS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIB_W-1:0]          in_dat,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIB_W*NIBS-1:0]     out_dat,
  output logic [$clog2(NIBS):0]     out_cnt,
  output logic [$clog2(NIBS)-1:0]   ptr
);
  localparam int WORD_W = NIB_W * NIBS;
  localparam int PTR_W = $clog2(NIBS);
  localparam int CNT_W = PTR_W + 1;
  logic [WORD_W-1:0] asm_q, asm_ins;
  logic [CNT_W-1:0] cnt_ins;
  logic [WORD_W+CNT_W-1:0] hold_q;
  logic flush_pend, flush_req, in_acc, last, out_free, emit;
  assign last = ptr == PTR_W'(NIBS - 1);
  assign in_ready = rst_n & (!last | out_free) & !flush_pend;
  assign in_acc = in_valid & in_ready;
  assign flush_req = flush | flush_pend;
  // unfilled slots of asm_q are always zero, so OR-ing inserts the nibble
  assign asm_ins = in_acc ? asm_q | (WORD_W'(in_dat) << (ptr * NIB_W)) : asm_q;
  assign cnt_ins = CNT_W'(ptr) + CNT_W'(in_acc);
  assign emit = (in_acc & last) | (flush_req & out_free & (cnt_ins != '0));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      asm_q <= '0;
      flush_pend <= 1'b0;
    end else begin
      ptr <= emit ? '0 : ptr + PTR_W'(in_acc);
      asm_q <= emit ? '0 : asm_ins;
      flush_pend <= flush_req & !emit & (cnt_ins != '0);
    end
  end
  word_hold_reg #(.W(WORD_W + CNT_W)) u_hold (
    .clk(clk),
    .rst_n(rst_n),
    .load(emit),
    .d({cnt_ins, asm_ins}),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .q(hold_q),
    .out_free(out_free)
  );
  assign {out_cnt, out_dat} = hold_q;
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: scoreboard bench for nibble_packer, directed vectors plus a random handshake run
module tb_nibble_packer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [3:0] in_dat = 4'h0;
  logic in_ready, out_valid;
  logic [15:0] out_dat;
  logic [2:0] out_cnt;
  logic [1:0] ptr;
  int checks = 0, errors = 0;
  logic [18:0] exp_q[$];
  logic [18:0] held;
  bit stall = 0, rnd_rdy = 0;
  logic [3:0] nib[10000];
  nibble_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_dat(in_dat),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_dat(out_dat),
    .out_cnt(out_cnt), .ptr(ptr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] n);
    bit ok = 0;
    int t = 0;
    in_valid = 1'b1;
    in_dat = n;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for nibble %0h", n);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) stall = 0;
    else begin
      if (stall) chk("hold_stable", {out_cnt, out_dat}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {out_cnt, out_dat});
        end else chk("word", {out_cnt, out_dat}, exp_q.pop_front());
      end
      stall = out_valid && !out_ready;
      held = {out_cnt, out_dat};
    end
  end
  always @(posedge clk) if (rnd_rdy) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    logic [15:0] w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_dat", out_dat, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_ptr", ptr, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({3'd4, 16'h4321});
    for (int i = 1; i <= 4; i++) send(4'(i));
    chk("t1_ptr", ptr, 0);
    chk("t1_valid", out_valid, 1);
    step();
    chk("t1_valid_one_cycle", out_valid, 0);
    out_ready = 1'b0;
    exp_q.push_back({3'd4, 16'h4321});
    exp_q.push_back({3'd4, 16'h8765});
    for (int i = 1; i <= 7; i++) send(4'(i));
    in_valid = 1'b1;
    in_dat = 4'h8;
    @(negedge clk);
    chk("t2_stall_ready", in_ready, 0);
    chk("t2_held", out_dat, 16'h4321);
    chk("t2_ptr", ptr, 3);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t2_no_bubble_valid", out_valid, 1);
    chk("t2_no_bubble_dat", out_dat, 16'h8765);
    step();
    exp_q.push_back({3'd2, 16'h00BA});
    send(4'hA);
    send(4'hB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_ptr", ptr, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_cnt", out_cnt, 2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_empty_flush", out_valid, 0);
    step();
    chk("t3_empty_flush2", out_valid, 0);
    exp_q.push_back({3'd3, 16'h0CBA});
    send(4'hA);
    send(4'hB);
    in_valid = 1'b1;
    in_dat = 4'hC;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("t4_cnt", out_cnt, 3);
    chk("t4_ptr", ptr, 0);
    step();
    out_ready = 1'b0;
    exp_q.push_back({3'd4, 16'h4321});
    exp_q.push_back({3'd1, 16'h0005});
    for (int i = 1; i <= 5; i++) send(4'(i));
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("pend_blocks_in", in_ready, 0);
    step();
    out_ready = 1'b1;
    step();
    chk("pend_dat", out_dat, 16'h0005);
    chk("pend_cnt", out_cnt, 1);
    step();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(4'(i));
    chk("t5_pre_ptr", ptr, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    chk("t5_valid", out_valid, 0);
    chk("t5_ptr", ptr, 0);
    chk("t5_dat", out_dat, 0);
    chk("t5_cnt", out_cnt, 0);
    out_ready = 1'b1;
    exp_q.push_back({3'd4, 16'h6789});
    send(4'h9);
    send(4'h8);
    send(4'h7);
    send(4'h6);
    step();
    for (int i = 0; i < 10000; i++) nib[i] = 4'($urandom);
    for (int k = 0; k < 2500; k++) begin
      w = {nib[4*k+3], nib[4*k+2], nib[4*k+1], nib[4*k]};
      exp_q.push_back({3'd4, w});
    end
    rnd_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(nib[i]);
    end
    rnd_rdy = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    step();
    chk("queue_drained", exp_q.size(), 0);
    chk("final_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
